// File: rtl/gen_evt_filt.sv
// gen_evt_filt: debounce filter + level/edge event detector with a coalescing
// valid/ready event interface. One instance per synchronized external line.
// Optional: define GEN_EVT_GLITCH_CNT_EN to add the glitch_cnt[7:0] output,
// a saturating count of rejected glitches.
module gen_evt_filt #(
    parameter int DB_CYC = 4,
    parameter int DB_W   = 4,
    parameter int CNT_W  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             data_syn,
    input  logic [1:0]       mode,
    output logic             level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             evt_ovf
`ifdef GEN_EVT_GLITCH_CNT_EN
    ,
    output logic [7:0]       glitch_cnt
`endif
);

    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_PEND   = 1'b1;
    localparam logic [DB_W-1:0]  DBC_LAST = DB_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             level_q, level_d;
    logic             lvl_d1_q;
    logic [DB_W-1:0]  dbc_q, dbc_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             hit;

    // Debounce: level flips only after DB_CYC consecutive differing samples.
    always_comb begin
        level_d = level_q;
        dbc_d   = dbc_q;
        if (data_syn == level_q) begin
            dbc_d = '0;
        end else if (dbc_q == DBC_LAST) begin
            level_d = data_syn;
            dbc_d   = '0;
        end else begin
            dbc_d = dbc_q + 1'b1;
        end
    end

    // Event detection on the filtered level; level mode re-arms only from IDLE.
    always_comb begin
        case (mode)
            2'b00:   hit = level_q & (state_q == S_IDLE);
            2'b01:   hit = level_q & ~lvl_d1_q;
            2'b10:   hit = ~level_q & lvl_d1_q;
            default: hit = level_q ^ lvl_d1_q;
        endcase
    end

    // Batch FSM: coalesce hits while the consumer has not accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d = S_PEND;
                    cnt_d   = CNT_ONE;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                if (evt_ready) begin
                    // an accept coinciding with a hit opens a fresh batch
                    if (hit) begin
                        cnt_d = CNT_ONE;
                        ovf_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end else if (hit) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    else                  ovf_d = 1'b1;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            level_q  <= 1'b0;
            lvl_d1_q <= 1'b0;
            dbc_q    <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            level_q  <= level_d;
            lvl_d1_q <= level_q;
            dbc_q    <= dbc_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef GEN_EVT_GLITCH_CNT_EN
    logic [7:0] glitch_q;

    // Count samples that returned to level before the debounce completed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            glitch_q <= '0;
        end else if ((dbc_q != '0) && (data_syn == level_q) && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

    assign level     = level_q;
    assign evt_valid = (state_q == S_PEND);
    assign evt_cnt   = cnt_q;
    assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_gen_evt_filt.sv
// Bench for gen_evt_filt: two instances (CNT_W=4 and CNT_W=2) share stimulus
// and are compared every cycle against a sample-window reference model, with
// directed scenarios followed by randomized runs.
module tb_gen_evt_filt;

    localparam int DB = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       data_syn;
    logic [1:0] mode;
    logic       evt_ready;

    logic       la, va, oa, lb, vb, ob;
    logic [3:0] ca;
    logic [1:0] cb;
`ifdef GEN_EVT_GLITCH_CNT_EN
    logic [7:0] ga, gb;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    bit   win[$];
    int   m_level, m_prev, m_glitch;
    int   m_pend[2], m_cnt[2], m_ovf[2];
    int   m_max[2] = '{15, 3};

    always #5 CLK = ~CLK;

    gen_evt_filt #(.DB_CYC(DB), .DB_W(4), .CNT_W(4)) dut_a (
        .CLK(CLK), .RST(RST), .data_syn(data_syn), .mode(mode),
        .level(la), .evt_valid(va), .evt_ready(evt_ready),
        .evt_cnt(ca), .evt_ovf(oa)
`ifdef GEN_EVT_GLITCH_CNT_EN
        , .glitch_cnt(ga)
`endif
    );

    gen_evt_filt #(.DB_CYC(DB), .DB_W(4), .CNT_W(2)) dut_b (
        .CLK(CLK), .RST(RST), .data_syn(data_syn), .mode(mode),
        .level(lb), .evt_valid(vb), .evt_ready(evt_ready),
        .evt_cnt(cb), .evt_ovf(ob)
`ifdef GEN_EVT_GLITCH_CNT_EN
        , .glitch_cnt(gb)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the applied inputs.
    task automatic model_edge(input bit d, input int md, input bit rdy, input bit rst);
        int  hit[2];
        int  nl;
        bit  all_diff;
        if (rst) begin
            win.delete();
            m_level = 0; m_prev = 0; m_glitch = 0;
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            case (md)
                0:       hit[i] = (m_level == 1 && m_pend[i] == 0) ? 1 : 0;
                1:       hit[i] = (m_level == 1 && m_prev == 0) ? 1 : 0;
                2:       hit[i] = (m_level == 0 && m_prev == 1) ? 1 : 0;
                default: hit[i] = (m_level != m_prev) ? 1 : 0;
            endcase
        end
        // a sample back at level right after an unfinished differing run
        if (win.size() > 0 && int'(win[$]) != m_level && int'(d) == m_level && m_glitch < 255)
            m_glitch++;
        win.push_back(d);
        if (win.size() > DB) void'(win.pop_front());
        all_diff = (win.size() == DB);
        foreach (win[k]) if (int'(win[k]) == m_level) all_diff = 1'b0;
        nl = all_diff ? int'(d) : m_level;
        for (int i = 0; i < 2; i++) begin
            if (m_pend[i] == 0) begin
                if (hit[i] != 0) begin m_pend[i] = 1; m_cnt[i] = 1; m_ovf[i] = 0; end
            end else if (rdy) begin
                if (hit[i] != 0) begin m_cnt[i] = 1; m_ovf[i] = 0; end
                else begin m_pend[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; end
            end else if (hit[i] != 0) begin
                if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                else m_ovf[i] = 1;
            end
        end
        m_prev  = m_level;
        m_level = nl;
    endtask

    // Drive one cycle, clock it, update the model and compare all outputs.
    task automatic step(input bit d, input int md, input bit rdy, input bit rst);
        data_syn  = d;
        mode      = 2'(md);
        evt_ready = rdy;
        RST       = rst;
        @(posedge CLK);
        model_edge(d, md, rdy, rst);
        #1;
        chk("lvl_a", int'(la), m_level);
        chk("vld_a", int'(va), m_pend[0]);
        chk("cnt_a", int'(ca), m_cnt[0]);
        chk("ovf_a", int'(oa), m_ovf[0]);
        chk("lvl_b", int'(lb), m_level);
        chk("vld_b", int'(vb), m_pend[1]);
        chk("cnt_b", int'(cb), m_cnt[1]);
        chk("ovf_b", int'(ob), m_ovf[1]);
`ifdef GEN_EVT_GLITCH_CNT_EN
        chk("glt_a", int'(ga), m_glitch);
        chk("glt_b", int'(gb), m_glitch);
`endif
    endtask

    task automatic pulse(input int md);
        repeat (6) step(1'b1, md, 1'b0, 1'b0);
        repeat (6) step(1'b0, md, 1'b0, 1'b0);
    endtask

    initial begin
        RST = 1'b1; data_syn = 1'b0; mode = 2'b01; evt_ready = 1'b0;
        model_edge(1'b0, 1, 1'b0, 1'b1);

        // reset state
        step(1'b0, 1, 1'b0, 1'b1);
        step(1'b0, 1, 1'b0, 1'b1);
        chk("rst_vld", int'(va), 0);
        chk("rst_cnt", int'(ca), 0);

        // rising edge latency: level after 4 edges, valid after 5
        for (int c = 1; c <= 10; c++) begin
            step(1'b1, 1, 1'b0, 1'b0);
            if (c == 3) chk("lat_lvl3", int'(la), 0);
            if (c == 4) chk("lat_lvl4", int'(la), 1);
            if (c == 4) chk("lat_vld4", int'(va), 0);
            if (c == 5) chk("lat_vld5", int'(va), 1);
            if (c == 10) chk("lat_cnt", int'(ca), 1);
        end

        // glitch of 3 cycles is rejected
        step(1'b0, 1, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1, 1'b0, 1'b0);
        chk("glt_lvl", int'(la), 0);
        chk("glt_vld", int'(va), 0);
`ifdef GEN_EVT_GLITCH_CNT_EN
        chk("glt_cnt", int'(ga), 1);
`endif

        // both edges: 3 pulses -> 6 events; narrow counter saturates
        repeat (3) pulse(3);
        chk("both_cnt_a", int'(ca), 6);
        chk("both_ovf_a", int'(oa), 0);
        chk("both_cnt_b", int'(cb), 3);
        chk("both_ovf_b", int'(ob), 1);
        step(1'b0, 3, 1'b1, 1'b0);
        chk("both_acc_vld", int'(va), 0);
        chk("both_acc_cnt", int'(ca), 0);

        // five rises saturate CNT_W=2
        repeat (5) pulse(1);
        chk("sat_cnt_b", int'(cb), 3);
        chk("sat_ovf_b", int'(ob), 1);
        chk("sat_cnt_a", int'(ca), 5);

        // accept coinciding with a new rise
        repeat (4) step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 1, 1'b1, 1'b0);
        chk("acc_hit_vld", int'(vb), 1);
        chk("acc_hit_cnt", int'(cb), 1);
        chk("acc_hit_ovf", int'(ob), 0);
        repeat (6) step(1'b0, 1, 1'b0, 1'b0);
        step(1'b0, 1, 1'b1, 1'b0);
        chk("acc_clr_vld", int'(vb), 0);
        chk("acc_clr_ovf", int'(ob), 0);

        // reset mid-batch, then input held high gives exactly one rise
        repeat (2) pulse(1);
        chk("mid_cnt", int'(ca), 2);
        step(1'b1, 1, 1'b0, 1'b1);
        chk("mid_rst_vld", int'(va), 0);
        chk("mid_rst_cnt", int'(ca), 0);
        chk("mid_rst_lvl", int'(la), 0);
        for (int c = 1; c <= 12; c++) begin
            step(1'b1, 1, 1'b0, 1'b0);
            if (c == 4) chk("mid_vld4", int'(va), 0);
            if (c == 5) chk("mid_vld5", int'(va), 1);
            if (c == 12) chk("mid_cnt12", int'(ca), 1);
        end

        // level mode: one batch per accept while level is high
        for (int c = 0; c < 8; c++) step(1'b1, 0, c[0], 1'b0);

        // randomized runs of varying length, modes, ready and rare resets
        begin
            bit v = 1'b0;
            int md = 1;
            for (int r = 0; r < 400; r++) begin
                int len;
                v = ~v;
                len = int'($urandom_range(1, 9));
                if ($urandom_range(0, 4) == 0) md = int'($urandom_range(0, 3));
                for (int c = 0; c < len; c++)
                    step(v, md, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
